result_writeback: RTL
=====================

RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
- REQ-001: Parameter NUM_FUBS, default 4; number of functional-unit result ports, range 2..8.
- REQ-002: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-003: reset  in  1  synchronous, active-low reset.
- REQ-004: fu_result  in  NUM_FUBS x Result_bus  per-FU res_a, res_b, cout, ov, crf, msr and valid.
- REQ-005: fu_gpr_a, fu_gpr_b  in  NUM_FUBS x 5  GPR destinations for res_a and res_b.
- REQ-006: fu_we_a, fu_we_b, fu_cr_we, fu_xer_we, fu_msr_we  in  NUM_FUBS x 1  per-result write qualifiers.
- REQ-007: fu_cr_sel  in  NUM_FUBS x 3  CR field index.
- REQ-008: fu_ready  out  NUM_FUBS  result accepted when fu_result[i].valid and fu_ready[i] are both high.
- REQ-009: wb_hold  in  1  register-file back-pressure; while high, no new grant is issued.
- REQ-010: gpr_wa_en/addr/data and gpr_wb_en/addr/data  out  1/5/32 each  two GPR write ports.
- REQ-011: cr_we 1, cr_sel 3, cr_data 4  out  CR field write.
- REQ-012: xer_we 1, xer_ca 1, xer_ov 1, xer_so 1  out  XER update.
- REQ-013: msr_we 1, msr_data 32  out  MSR write.
- REQ-014: wb_count  out  16  count of committed writebacks.

Function
- REQ-015: Each FU has a one-entry holding buffer; fu_ready[i] = buffer empty OR buffer granted this cycle.
- REQ-016: A handshake in cycle N loads the buffer at the end of N; the entry is eligible for grant in N+1.
- REQ-017: Round-robin arbiter: one grant per cycle among occupied buffers, searching upward from pointer.
- REQ-018: After a grant to index i, the pointer becomes (i+1) mod NUM_FUBS; with no grant, the pointer is unchanged.
- REQ-019: A granted buffer empties at the end of the grant cycle; a new result may load the same edge, with no bubble.
- REQ-020: Granted entry is registered to the outputs; the outputs are valid in the cycle after the grant (best-case latency 2 cycles from handshake).
- REQ-021: Output enables are high for exactly one cycle per grant; all enables are low in cycles with no grant.
- REQ-022: gpr_wa_en = we_a, gpr_wb_en = we_b; if both are set and addresses are equal, gpr_wa_en is forced low (port b wins).
- REQ-023: cr_data = crf, written when cr_we is set.
- REQ-024: When xer_we is set: xer_ca = cout, xer_ov = ov, and internal SO becomes SO OR ov.
- REQ-025: xer_so always reflects the internal sticky SO.
- REQ-026: wb_hold high in cycle N: no grant in N, buffers retain contents, pointer unchanged, all enables low in N+1.
- REQ-027: Outputs already registered still commit regardless of wb_hold.
- REQ-028: wb_count increments by 1 per grant; 16'hFFFF wraps to 0.
- REQ-029: fu_result[i].valid while fu_ready[i] is low is ignored; the FU must hold the result stable.

Reset
- REQ-030: reset low at an edge: all buffers emptied, pointer = 0, all enables 0, data outputs 0, sticky SO 0, wb_count 0.
- REQ-031: A reset asserted mid-operation discards buffered results without committing them.
- REQ-032: fu_ready is all ones in the first cycle after reset is released.

Configuration
- REQ-033: Macro RESULT_WB_MSR_EN defined: msr_we = granted fu_msr_we, msr_data = granted res msr, registered like the other outputs.
- REQ-034: Macro RESULT_WB_MSR_EN undefined: msr_we and msr_data are held at 0, and fu_msr_we and msr are ignored.

Verification
- REQ-035: FU0 handshake in cycle 1 (res_a=32'h1234, gpr_a=3, we_a) -> cycle 3: gpr_wa_en=1, addr=3, data=32'h1234, for one cycle only.
- REQ-036: All 4 FUs valid in the same cycle, pointer 0 -> commits in order FU0, FU1, FU2, FU3 in 4 consecutive cycles; fu_ready per REQ-015.
- REQ-037: wb_hold high for 3 cycles with 2 buffers full -> no enables during that window; both commit after release, with no loss or duplication.
- REQ-038: Two xer_we results, ov=1 then ov=0 -> xer_ov goes 1 then 0; xer_so stays 1 until reset.
- REQ-039: we_a and we_b both set with gpr_a = gpr_b = 7 -> only gpr_wb_en high, carrying res_b.
- REQ-040: Reset pulsed with 3 buffers full -> no commits; wb_count=0; fu_ready all ones.

Source files
------------

// File: rtl/result_writeback.sv
// result_writeback
//   Collects results from NUM_FUBS functional units and commits at most one
//   of them per cycle to the register files (two GPR write ports, one CR
//   field, XER and optionally MSR).
//
//   Each FU owns a one-entry holding buffer. A round-robin arbiter picks one
//   occupied buffer per cycle, and the picked entry is registered onto the
//   write ports. The best-case latency is two cycles from handshake to
//   commit.
//
//   Optional feature: define RESULT_WB_MSR_EN to enable the MSR write port.
//   Without the macro, msr_we and msr_data are tied to zero, and the
//   fu_msr_we and msr inputs are ignored.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   fu_result[i]      res_a, res_b, cout, ov, crf, msr and valid from FU i
//   fu_gpr_a/b[i]     GPR destination indices for res_a / res_b
//   fu_we_a/b, fu_cr_we, fu_xer_we, fu_msr_we  per-FU write qualifiers
//   fu_cr_sel[i]      CR field index
//   fu_ready[i]       FU i's result is accepted when valid and ready are both high
//   wb_hold           register-file back-pressure; suppresses new grants
//   gpr_wa_*/gpr_wb_* two GPR write ports (en / addr / data)
//   cr_we/sel/data    CR field write
//   xer_we/ca/ov/so   XER update; xer_so is the sticky summary overflow
//   msr_we/data       MSR write (only with RESULT_WB_MSR_EN)
//   wb_count          free-running count of grants (wraps at 16 bits)

package result_writeback_pkg;
  typedef struct packed {
    logic [31:0] res_a;
    logic [31:0] res_b;
    logic        cout;
    logic        ov;
    logic [3:0]  crf;
    logic [31:0] msr;
    logic        valid;
  } result_bus_t;
endpackage

module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int NUM_FUBS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  result_bus_t         fu_result [NUM_FUBS],
  input  logic [4:0]          fu_gpr_a  [NUM_FUBS],
  input  logic [4:0]          fu_gpr_b  [NUM_FUBS],
  input  logic [NUM_FUBS-1:0] fu_we_a,
  input  logic [NUM_FUBS-1:0] fu_we_b,
  input  logic [NUM_FUBS-1:0] fu_cr_we,
  input  logic [NUM_FUBS-1:0] fu_xer_we,
  input  logic [NUM_FUBS-1:0] fu_msr_we,
  input  logic [2:0]          fu_cr_sel [NUM_FUBS],
  output logic [NUM_FUBS-1:0] fu_ready,
  input  logic                wb_hold,
  output logic                gpr_wa_en,
  output logic [4:0]          gpr_wa_addr,
  output logic [31:0]         gpr_wa_data,
  output logic                gpr_wb_en,
  output logic [4:0]          gpr_wb_addr,
  output logic [31:0]         gpr_wb_data,
  output logic                cr_we,
  output logic [2:0]          cr_sel,
  output logic [3:0]          cr_data,
  output logic                xer_we,
  output logic                xer_ca,
  output logic                xer_ov,
  output logic                xer_so,
  output logic                msr_we,
  output logic [31:0]         msr_data,
  output logic [15:0]         wb_count
);

  localparam int IW  = $clog2(NUM_FUBS);
  localparam int IW1 = IW + 1;

  // Buffer occupancy and arbitration state
  logic [NUM_FUBS-1:0] occ;
  logic [IW-1:0]       ptr;
  logic                grant_valid;
  logic [IW-1:0]       grant_idx;
  logic [IW1-1:0]      cand;
  logic [NUM_FUBS-1:0] grant_hit;
  logic [NUM_FUBS-1:0] load;

  // Buffer payload (no reset needed; only read while occupied)
  logic [31:0]         buf_res_a [NUM_FUBS];
  logic [31:0]         buf_res_b [NUM_FUBS];
  logic [3:0]          buf_crf   [NUM_FUBS];
  logic [4:0]          buf_gpr_a [NUM_FUBS];
  logic [4:0]          buf_gpr_b [NUM_FUBS];
  logic [2:0]          buf_cr_sel[NUM_FUBS];
  logic [NUM_FUBS-1:0] buf_cout;
  logic [NUM_FUBS-1:0] buf_ov;
  logic [NUM_FUBS-1:0] buf_we_a;
  logic [NUM_FUBS-1:0] buf_we_b;
  logic [NUM_FUBS-1:0] buf_cr_we;
  logic [NUM_FUBS-1:0] buf_xer_we;

  // Round-robin search starting at ptr. The candidate index is wrapped with
  // a single conditional subtract, so NUM_FUBS need not be a power of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_FUBS; k++) begin
      cand = {1'b0, ptr} + IW1'(k);
      if (cand >= IW1'(NUM_FUBS)) begin
        cand = cand - IW1'(NUM_FUBS);
      end
      if (!wb_hold && !grant_valid && occ[cand[IW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  // A buffer being granted this cycle can accept a new result on the same edge.
  for (genvar gi = 0; gi < NUM_FUBS; gi++) begin : g_fu
    assign grant_hit[gi] = grant_valid && (grant_idx == IW'(gi));
    assign fu_ready[gi]  = !occ[gi] || grant_hit[gi];
    assign load[gi]      = fu_result[gi].valid && fu_ready[gi];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ <= '0;
      ptr <= '0;
    end else begin
      // A load wins over the grant's clear, which gives back-to-back refill.
      occ <= (occ & ~grant_hit) | load;
      if (grant_valid) begin
        ptr <= (grant_idx == IW'(NUM_FUBS - 1)) ? '0 : grant_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FUBS; i++) begin
      if (load[i]) begin
        buf_res_a[i]  <= fu_result[i].res_a;
        buf_res_b[i]  <= fu_result[i].res_b;
        buf_crf[i]    <= fu_result[i].crf;
        buf_cout[i]   <= fu_result[i].cout;
        buf_ov[i]     <= fu_result[i].ov;
        buf_gpr_a[i]  <= fu_gpr_a[i];
        buf_gpr_b[i]  <= fu_gpr_b[i];
        buf_cr_sel[i] <= fu_cr_sel[i];
        buf_we_a[i]   <= fu_we_a[i];
        buf_we_b[i]   <= fu_we_b[i];
        buf_cr_we[i]  <= fu_cr_we[i];
        buf_xer_we[i] <= fu_xer_we[i];
      end
    end
  end

  // Registered write ports. Enables pulse for one cycle per grant. Data and
  // address fields keep their last granted value between grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpr_wa_en   <= 1'b0;
      gpr_wa_addr <= '0;
      gpr_wa_data <= '0;
      gpr_wb_en   <= 1'b0;
      gpr_wb_addr <= '0;
      gpr_wb_data <= '0;
      cr_we       <= 1'b0;
      cr_sel      <= '0;
      cr_data     <= '0;
      xer_we      <= 1'b0;
      xer_ca      <= 1'b0;
      xer_ov      <= 1'b0;
      xer_so      <= 1'b0;
      wb_count    <= '0;
    end else begin
      gpr_wa_en <= 1'b0;
      gpr_wb_en <= 1'b0;
      cr_we     <= 1'b0;
      xer_we    <= 1'b0;
      if (grant_valid) begin
        // If both ports target the same GPR, port b carries the surviving value.
        gpr_wa_en   <= buf_we_a[grant_idx] &&
                       !(buf_we_b[grant_idx] && (buf_gpr_a[grant_idx] == buf_gpr_b[grant_idx]));
        gpr_wa_addr <= buf_gpr_a[grant_idx];
        gpr_wa_data <= buf_res_a[grant_idx];
        gpr_wb_en   <= buf_we_b[grant_idx];
        gpr_wb_addr <= buf_gpr_b[grant_idx];
        gpr_wb_data <= buf_res_b[grant_idx];
        cr_we       <= buf_cr_we[grant_idx];
        cr_sel      <= buf_cr_sel[grant_idx];
        cr_data     <= buf_crf[grant_idx];
        xer_we      <= buf_xer_we[grant_idx];
        if (buf_xer_we[grant_idx]) begin
          xer_ca <= buf_cout[grant_idx];
          xer_ov <= buf_ov[grant_idx];
          xer_so <= xer_so | buf_ov[grant_idx];
        end
        wb_count <= wb_count + 16'd1;
      end
    end
  end

`ifdef RESULT_WB_MSR_EN
  logic [31:0]         buf_msr    [NUM_FUBS];
  logic [NUM_FUBS-1:0] buf_msr_we;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FUBS; i++) begin
      if (load[i]) begin
        buf_msr[i]    <= fu_result[i].msr;
        buf_msr_we[i] <= fu_msr_we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      msr_we   <= 1'b0;
      msr_data <= '0;
    end else begin
      msr_we <= 1'b0;
      if (grant_valid) begin
        msr_we   <= buf_msr_we[grant_idx];
        msr_data <= buf_msr[grant_idx];
      end
    end
  end
`else
  assign msr_we   = 1'b0;
  assign msr_data = '0;

  // MSR inputs have no function in this build.
  logic unused_msr;
  always_comb begin
    unused_msr = ^fu_msr_we;
    for (int i = 0; i < NUM_FUBS; i++) begin
      unused_msr = unused_msr ^ (^fu_result[i].msr);
    end
  end
`endif

endmodule
